pow_seq_ctrl: RTL and testbench
===============================

Name: pow_seq_ctrl

Overview:
- Multi-cycle sequencer for the Verilog power operator y = a ** b, result truncated to WIDTH bits.
- Signed and unsigned operands are selected per request; the full IEEE 1364 negative-exponent rules apply.
- Drives a shared square-and-multiply datapath, one exponent bit per cycle, with valid/ready handshakes on both sides.
- Serves as the golden sequential reference for power-operator checks in the expression-evaluation test suite.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  base.
- b  input  WIDTH  exponent.
- a_signed  input  1  a is a signed value.
- b_signed  input  1  b is a signed value.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- y  output  WIDTH  result, a ** b mod 2^WIDTH.
- y_undef  output  1  result is x per the Verilog rules (0 ** negative).
- run_cycles  output  WIDTH  number of RUN cycles the last operation used.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0 while rst_n is low, out_valid=0, y=0, y_undef=0, run_cycles=0, internal regs cleared.
- Reset mid-operation aborts the operation; no result is produced.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE) && rst_n.
- Acceptance: in_valid && in_ready at a rising edge latches a, b, a_signed, b_signed.
- in_valid outside IDLE is ignored; inputs are not sampled then.
- Fast path, IDLE->DONE directly; out_valid is high in cycle c+1, where c is the acceptance cycle; run_cycles=0:
  - b==0: y=1, including 0**0.
  - b_signed && b[WIDTH-1] (negative exponent), decided by a:
    - a==0: y=0, y_undef=1.
    - a==1: y=1.
    - a_signed && a==all-ones (-1): y=all-ones if b is odd, else 1.
    - otherwise: y=0.
  - An unsigned all-ones a is 2^WIDTH-1, not -1, so it yields 0 for a negative exponent.
- RUN path, any other case, with b treated as an unsigned magnitude:
  - Load res=1, base=a, e=b.
  - Each RUN cycle: if e[0] then res<=res*base; base<=base*base; e<=e>>1. All products are truncated to WIDTH.
  - When the shifted e is 0, go to DONE.
  - m = index of the MSB of b. RUN lasts m+1 cycles; out_valid is high in cycle c+m+2; run_cycles=m+1.
- Signedness of a does not affect the RUN result, because the truncated product is identical.
- DONE: out_valid=1; y, y_undef and run_cycles are stable.
  - out_valid && out_ready at an edge -> IDLE; out_valid drops and in_ready rises the next cycle.
  - No back-to-back accept in the handover cycle.
- y, y_undef and run_cycles hold their last values in IDLE/RUN until the next DONE update.
- y_undef is cleared on every non-undef result.
- Multiplier width is WIDTH x WIDTH -> WIDTH. No internal x is ever driven.

Test Plan:
- WIDTH=8, a=3, b=2, both unsigned -> y=8'd9, y_undef=0, run_cycles=2, out_valid in cycle c+3.
- a=8'sd-3 (8'hFD, signed), b=8'd3 (unsigned) -> y=8'hE5 (-27), run_cycles=2. a=8'hFE (signed), b=8'hFE (unsigned, 254) -> y=0, run_cycles=8, out_valid in cycle c+9.
- Negative-exponent fast path, b signed, out_valid in cycle c+1, run_cycles=0:
  - a=0, b=-1 -> y=0, y_undef=1.
  - a=1, b=-2 -> y=1.
  - a=-1 signed, b=-3 -> y=8'hFF.
  - a=-1 signed, b=-2 -> y=1.
  - a=8'hFF unsigned, b=-2 -> y=0.
  - a=-2, b=-3 -> y=0.
- a=0, b=0 -> y=1 via fast path. a=5, b=1 -> y=5, run_cycles=1.
- Backpressure:
  - After out_valid, hold out_ready=0 for 5 cycles while driving in_valid=1 with different operands -> y stable, in_ready=0, new request not accepted.
  - Raise out_ready -> IDLE, in_ready=1 next cycle, queued request accepted then.
- Mid-run reset: assert rst_n=0 during the 4th RUN cycle of a=3, b=8'h80 -> outputs 0 immediately, no out_valid.
  - After release, a=2, b=3 completes with y=8 and run_cycles=2.

Source files
------------

// File: rtl/pow_seq_ctrl_if.sv
// rtl/pow_seq_ctrl_if.sv - request/response handshake bundle for the power-operator sequencer
interface pow_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_signed;
  logic             b_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_undef;
  logic [WIDTH-1:0] run_cycles;

  // Requester / result consumer side
  modport master (
    output in_valid, a, b, a_signed, b_signed, out_ready,
    input  in_ready, out_valid, y, y_undef, run_cycles
  );

  // Sequencer side
  modport slave (
    input  in_valid, a, b, a_signed, b_signed, out_ready,
    output in_ready, out_valid, y, y_undef, run_cycles
  );
endinterface

// File: rtl/pow_seq_ctrl.sv
// rtl/pow_seq_ctrl.sv - square-and-multiply sequencer for y = a ** b truncated to WIDTH bits
module pow_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pow_seq_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] rc_q, rc_d;
  logic             undef_q, undef_d;

  logic [WIDTH-1:0] prod_res;
  logic [WIDTH-1:0] prod_base;
  logic [WIDTH-1:0] e_shift;
  logic             b_neg;

  // Shared datapath: both products truncated to WIDTH, which also makes base signedness irrelevant
  assign prod_res  = res_q * base_q;
  assign prod_base = base_q * base_q;
  assign e_shift   = e_q >> 1;
  assign b_neg     = bus.b_signed && bus.b[WIDTH-1];

  assign bus.in_ready   = (state_q == S_IDLE) && rst_n;
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.y          = y_q;
  assign bus.y_undef    = undef_q;
  assign bus.run_cycles = rc_q;

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      base_q  <= '0;
      e_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      rc_q    <= '0;
      undef_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      base_q  <= base_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      rc_q    <= rc_d;
      undef_q <= undef_d;
    end
  end

  // Next-state: fast-path decode on accept, one exponent bit per RUN cycle, hold in DONE until taken
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    base_d  = base_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    rc_d    = rc_q;
    undef_d = undef_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.b == ZERO) begin
            // Anything to the zeroth power is 1, 0**0 included
            y_d     = ONE;
            undef_d = 1'b0;
            rc_d    = '0;
            state_d = S_DONE;
          end else if (b_neg) begin
            // Negative exponent: only 0, 1 and signed -1 give a non-zero or undefined result
            undef_d = 1'b0;
            rc_d    = '0;
            state_d = S_DONE;
            if (bus.a == ZERO) begin
              y_d     = ZERO;
              undef_d = 1'b1;
            end else if (bus.a == ONE) begin
              y_d = ONE;
            end else if (bus.a_signed && (bus.a == ONES)) begin
              y_d = bus.b[0] ? ONES : ONE;
            end else begin
              y_d = ZERO;
            end
          end else begin
            res_d   = ONE;
            base_d  = bus.a;
            e_d     = bus.b;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (e_q[0]) begin
          res_d = prod_res;
        end
        base_d = prod_base;
        e_d    = e_shift;
        cnt_d  = cnt_q + ONE;
        if (e_shift == ZERO) begin
          y_d     = e_q[0] ? prod_res : res_q;
          undef_d = 1'b0;
          rc_d    = cnt_q + ONE;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pow_seq_ctrl.sv
// tb/tb_pow_seq_ctrl.sv - self-checking bench for pow_seq_ctrl
module tb_pow_seq_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  pow_seq_ctrl_if #(.WIDTH(W)) bus ();

  pow_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         as;
    logic         bs;
    logic [W-1:0] y;
    logic         undef;
    logic [W-1:0] rc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Reference: repeated multiplication modulo 2^W, Verilog negative-exponent rules
  task automatic ref_pow(input logic [W-1:0] a, input logic [W-1:0] b, input logic as,
                         input logic bs, output logic [W-1:0] y, output logic undef,
                         output logic [W-1:0] rc);
    int r;
    int msb;
    undef = 1'b0;
    rc    = '0;
    if (b == 0) begin
      y = 1;
    end else if (bs && b[W-1]) begin
      if (a == 0) begin
        y = 0;
        undef = 1'b1;
      end else if (a == 1) begin
        y = 1;
      end else if (as && a == {W{1'b1}}) begin
        y = b[0] ? {W{1'b1}} : W'(1);
      end else begin
        y = 0;
      end
    end else begin
      r = 1;
      for (int i = 0; i < int'(b); i++) r = (r * int'(a)) % (1 << W);
      y = W'(r);
      msb = 0;
      for (int i = 0; i < W; i++) if (b[i]) msb = i;
      rc = W'(msb + 1);
    end
  endtask

  // Present a request, wait for the result, check value and latency, then consume it
  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic as, input logic bs, input logic [W-1:0] ey,
                       input logic eu, input logic [W-1:0] erc);
    int guard;
    int lat;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.a_signed = as; bus.b_signed = bs; bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      chk({nm, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_latency"}, lat, (erc == 0) ? 1 : int'(erc) + 1);
    chk({nm, "_y"}, 32'(bus.y), 32'(ey));
    chk({nm, "_undef"}, 32'(bus.y_undef), 32'(eu));
    chk({nm, "_rc"}, 32'(bus.run_cycles), 32'(erc));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, "_drop"}, {bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  initial begin
    logic [W-1:0] ry, rrc, ra, rb;
    logic ru, ras, rbs;
    int guard;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.a_signed = 1'b0; bus.b_signed = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", {bus.in_ready, bus.out_valid, bus.y_undef, bus.y, bus.run_cycles},
        32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    vecs.push_back('{8'd3,   8'd2,   1'b0, 1'b0, 8'd9,   1'b0, 8'd2});
    vecs.push_back('{8'hFD,  8'd3,   1'b1, 1'b0, 8'hE5,  1'b0, 8'd2});
    vecs.push_back('{8'hFE,  8'hFE,  1'b1, 1'b0, 8'd0,   1'b0, 8'd8});
    vecs.push_back('{8'd0,   8'hFF,  1'b0, 1'b1, 8'd0,   1'b1, 8'd0});
    vecs.push_back('{8'd1,   8'hFE,  1'b0, 1'b1, 8'd1,   1'b0, 8'd0});
    vecs.push_back('{8'hFF,  8'hFD,  1'b1, 1'b1, 8'hFF,  1'b0, 8'd0});
    vecs.push_back('{8'hFF,  8'hFE,  1'b1, 1'b1, 8'd1,   1'b0, 8'd0});
    vecs.push_back('{8'hFF,  8'hFE,  1'b0, 1'b1, 8'd0,   1'b0, 8'd0});
    vecs.push_back('{8'hFE,  8'hFD,  1'b1, 1'b1, 8'd0,   1'b0, 8'd0});
    vecs.push_back('{8'd0,   8'd0,   1'b0, 1'b0, 8'd1,   1'b0, 8'd0});
    vecs.push_back('{8'd5,   8'd1,   1'b0, 1'b0, 8'd5,   1'b0, 8'd1});
    vecs.push_back('{8'd2,   8'd7,   1'b0, 1'b0, 8'd128, 1'b0, 8'd3});

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs,
            vecs[i].y, vecs[i].undef, vecs[i].rc);

    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      rb  = (i % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      ras = 1'($urandom);
      rbs = 1'($urandom);
      if (i % 7 == 0) ra = W'($urandom_range(0, 1));
      if (i % 5 == 0) ra = '1;
      ref_pow(ra, rb, ras, rbs, ry, ru, rrc);
      do_op($sformatf("rnd%0d", i), ra, rb, ras, rbs, ry, ru, rrc);
    end

    // Backpressure: result held while a new request waits
    @(negedge clk);
    bus.a = 8'd3; bus.b = 8'd2; bus.a_signed = 1'b0; bus.b_signed = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.a = 8'd7;
    guard = 0;
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k), {bus.out_valid, bus.in_ready, bus.y}, {2'b10, 8'd9});
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_handover", {bus.out_valid, bus.in_ready}, 32'b01);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_queued_y", {bus.out_valid, bus.y, bus.run_cycles}, {1'b1, 8'd49, 8'd2});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Mid-run reset during the 4th RUN cycle
    bus.a = 8'd3; bus.b = 8'h80; bus.a_signed = 1'b0; bus.b_signed = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {bus.in_ready, bus.out_valid, bus.y_undef, bus.y, bus.run_cycles},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) chk("midrst_no_result", 32'(bus.out_valid), 32'd0);
    end
    chk("midrst_idle", {bus.out_valid, bus.in_ready}, 32'b01);
    do_op("after_rst", 8'd2, 8'd3, 1'b0, 1'b0, 8'd8, 1'b0, 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
